// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in / serial-out frame transmitter.
// Frame = start(0), DATA_W data bits MSB first, even parity, stop(1),
// each bit held CLKS_PER_BIT clocks. Keeps a two-digit BCD count of
// completed frames for the HEX displays.
module serial_frame_tx #(
  parameter int DATA_W       = 10,
  parameter int CLKS_PER_BIT = 5000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              serial_out,
  output logic              busy,
  output logic              done,
  output logic [3:0]        bit_index,
  output logic [3:0]        frames_lo,
  output logic [3:0]        frames_hi
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    TOP_IDX = 4'(DATA_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        state;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nxt;
  logic              parity_bit;
  logic              bit_end;

  assign bit_end = (timer == LAST);
  assign sh_nxt  = sh << 1;

  // busy and done are decodes of registered state only, so start never
  // reaches them (or serial_out) combinationally.
  assign busy = (state != IDLE);
  assign done = (state == STOP) && bit_end;

  // Bit timer: free-runs 0..CLKS_PER_BIT-1 while a frame is active.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)              timer <= '0;
    else if (state == IDLE) timer <= '0;
    else if (bit_end)       timer <= '0;
    else                    timer <= timer + 1'b1;
  end

  // Frame sequencer: serial_out is registered one state ahead so the line
  // changes exactly on bit boundaries.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      parity_bit <= 1'b0;
      serial_out <= 1'b1;
      bit_index  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          bit_index  <= 4'd0;
          if (start) begin
            sh         <= data_in;
            parity_bit <= ^data_in;
            serial_out <= 1'b0;
            state      <= START;
          end
        end
        START: if (bit_end) begin
          state      <= DATA;
          bit_index  <= TOP_IDX;
          serial_out <= sh[DATA_W-1];
        end
        DATA: if (bit_end) begin
          sh <= sh_nxt;
          if (bit_index == 4'd0) begin
            state      <= PARITY;
            serial_out <= parity_bit;
          end else begin
            bit_index  <= bit_index - 1'b1;
            serial_out <= sh_nxt[DATA_W-1];
          end
        end
        PARITY: if (bit_end) begin
          state      <= STOP;
          serial_out <= 1'b1;
        end
        STOP: if (bit_end) begin
          state      <= IDLE;
          serial_out <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
          bit_index  <= 4'd0;
        end
      endcase
    end
  end

  // Two-digit BCD count of completed frames, wrapping 99 -> 00.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      frames_lo <= 4'd0;
      frames_hi <= 4'd0;
    end else if (done) begin
      if (frames_lo == 4'd9) begin
        frames_lo <= 4'd0;
        frames_hi <= (frames_hi == 4'd9) ? 4'd0 : frames_hi + 1'b1;
      end else begin
        frames_lo <= frames_lo + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a frame-position model predicts every output
// each cycle; directed tests pin the model with hand-computed literals.
module tb_serial_frame_tx;

  localparam int DW  = 10;
  localparam int CPB = 4;
  localparam int LEN = (DW + 3) * CPB;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] data_in;
  logic          serial_out, busy, done;
  logic [3:0]    bit_index, frames_lo, frames_hi;

  int checks = 0;
  int fails  = 0;

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .data_in(data_in),
    .serial_out(serial_out), .busy(busy), .done(done), .bit_index(bit_index),
    .frames_lo(frames_lo), .frames_hi(frames_hi)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frame as a flat list of bit slots ----------------
  logic          m_active;
  int            m_pos;
  logic [DW-1:0] m_word;
  int            m_count;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_count  <= 0;
    end else if (m_active) begin
      if (m_pos == LEN - 1) begin
        m_active <= 1'b0;
        m_count  <= (m_count + 1) % 100;
      end else begin
        m_pos <= m_pos + 1;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_pos    <= 0;
      m_word   <= data_in;
    end
  end

  function automatic int exp_line(input int pos, input logic [DW-1:0] w);
    int slot;
    slot = pos / CPB;
    if (slot == 0)  return 0;
    if (slot <= DW) return int'(w[DW - slot]);
    if (slot == DW + 1) return int'(^w);
    return 1;
  endfunction

  function automatic int exp_idx(input int pos);
    int slot;
    slot = pos / CPB;
    if (slot >= 1 && slot <= DW) return DW - slot;
    return 0;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      chk("line",  int'(serial_out), m_active ? exp_line(m_pos, m_word) : 1);
      chk("busy",  int'(busy), int'(m_active));
      chk("done",  int'(done), int'(m_active && m_pos == LEN - 1));
      chk("index", int'(bit_index), m_active ? exp_idx(m_pos) : 0);
      chk("flo",   int'(frames_lo), m_count % 10);
      chk("fhi",   int'(frames_hi), m_count / 10);
    end
  end

  // ---------------- directed capture ----------------
  logic line [0:63];
  int   busy_cnt, done_cnt, done_idx;

  // Start a frame, then record 60 cycles of the line. Optionally re-assert
  // start at cycles 10, 30 and the done cycle, and/or scramble data_in.
  task automatic send_capture(input logic [DW-1:0] w, input bit inject, input bit scramble);
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    @(negedge CLOCK_50);
    data_in = w; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      line[c] = serial_out;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_idx = c; end
      start = inject && (c == 10 || c == 30 || c == 52);
      if (scramble) data_in = DW'($urandom);
      @(negedge CLOCK_50);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [12:0] exp_seq;
    logic [DW-1:0] rx;
    int base;
    bit got;

    start = 1'b0; data_in = '0; reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    chk("rst_line", int'(serial_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx",  int'(bit_index), 0);
    chk("rst_frm",  int'({frames_hi, frames_lo}), 0);
    reset = 1'b0;

    // Frame 1: literal line sequence, busy length, done position.
    send_capture(10'b1011001110, 1'b0, 1'b0);
    exp_seq = 13'b0_1011001110_0_1;
    for (int s = 0; s < 13; s++) chk("f1_slot", int'(line[s*CPB + 2]), int'(exp_seq[12 - s]));
    chk("f1_busy", busy_cnt, 52);
    chk("f1_done_at", done_idx, 52);
    chk("f1_frames", int'({frames_hi, frames_lo}), 8'h01);

    // Frame 2: receiver model recovers the word, parity is 1 and even overall.
    send_capture(10'b0000000111, 1'b0, 1'b0);
    rx = '0;
    for (int s = 1; s <= DW; s++) rx = {rx[DW-2:0], line[s*CPB + 2]};
    chk("f2_rx", int'(rx), 7);
    chk("f2_par", int'(line[(DW+1)*CPB + 2]), 1);
    chk("f2_even", int'(^{rx, line[(DW+1)*CPB + 2]}), 0);

    // Frame 3: starts while busy ignored, data_in scrambled mid-frame.
    send_capture(10'b1100101011, 1'b1, 1'b1);
    exp_seq = 13'b0_1100101011_0_1;
    for (int s = 0; s < 13; s++) chk("f3_slot", int'(line[s*CPB + 2]), int'(exp_seq[12 - s]));
    chk("f3_dones", done_cnt, 1);
    chk("f3_frames", int'({frames_hi, frames_lo}), 8'h03);

    // Reset mid-DATA at cycle 20: line idles immediately, no done.
    @(negedge CLOCK_50);
    data_in = 10'b1010101010; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (19) @(negedge CLOCK_50);
    chk("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_line", int'(serial_out), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_frm",  int'({frames_hi, frames_lo}), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    send_capture(10'b1011001110, 1'b0, 1'b0);
    exp_seq = 13'b0_1011001110_0_1;
    for (int s = 0; s < 13; s++) chk("f4_slot", int'(line[s*CPB + 2]), int'(exp_seq[12 - s]));
    chk("f4_done_at", done_idx, 52);
    chk("f4_frames", int'({frames_hi, frames_lo}), 8'h01);

    // 100 back-to-back frames from a cleared counter.
    @(negedge CLOCK_50); reset = 1'b1;
    @(negedge CLOCK_50); reset = 1'b0;
    done_cnt = 0;
    @(negedge CLOCK_50);
    data_in = 10'b0110011001; start = 1'b1;
    for (int f = 1; f <= 100; f++) begin
      @(negedge CLOCK_50);
      start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < LEN + 8 && !got; c++) begin
        if (done) got = 1'b1;
        else @(negedge CLOCK_50);
      end
      chk("b2b_done_seen", int'(got), 1);
      if (!got) break;
      done_cnt++;
      @(negedge CLOCK_50);
      if (f == 9)   chk("b2b_09", int'({frames_hi, frames_lo}), 8'h09);
      if (f == 10)  chk("b2b_10", int'({frames_hi, frames_lo}), 8'h10);
      if (f == 99)  chk("b2b_99", int'({frames_hi, frames_lo}), 8'h99);
      if (f == 100) chk("b2b_00", int'({frames_hi, frames_lo}), 8'h00);
      if (f < 100) begin
        data_in = DW'(f * 37); start = 1'b1;
      end
    end
    chk("b2b_count", done_cnt, 100);
    repeat (3) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
